dropout_mask_scheduler: RTL and testbench
=========================================

Name: dropout_mask_scheduler

Overview:
- Sequences random dropout for the 8-neuron datapath.
- Generates a per-lane drop mask from a 16-bit LFSR, one lane per cycle, against a programmable drop threshold.
- Applies the mask to a stream of 8-bit neuron vectors over a valid/ready handshake.
- Reuses each mask for a programmable number of vectors, then regenerates it; bypasses all dropout when not in training mode.

Parameters:
- LANES, 8: neurons per vector; also the mask width and the GEN length in cycles.
- LFSR_W, 16: LFSR width.
- SEED_DEFAULT, 16'hACE1: LFSR value after reset; also substituted for a zero seed.
- REUSE_W, 4: width of reuse_cnt.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-high (asserted = 1), sampled on clk.
- ena  input  1  training mode; 1 = dropout active, 0 = bypass.
- drop_thresh  input  8  drop probability ≈ drop_thresh/256, sampled at GEN entry.
- reuse_cnt  input  REUSE_W  vectors per mask; 0 is treated as 1; sampled at GEN exit.
- seed_load  input  1  one-cycle pulse that loads seed_val into the LFSR.
- seed_val  input  LFSR_W  seed value.
- in_valid  input  1  input vector valid.
- in_ready  output  1  scheduler accepts a vector this cycle.
- in_data  input  LANES  input neuron vector.
- out_valid  output  1  output vector valid.
- out_ready  input  1  downstream accepts.
- out_data  output  LANES  masked vector.
- mask  output  LANES  current mask; 1 = keep.
- gen_busy  output  1  high while state = GEN.
- drop_count  output  4  number of zeros in the last completed mask.

Behaviour:
- Reset values: state IDLE, lfsr = SEED_DEFAULT, mask = 8'hFF, out_valid = 0, out_data = 0, gen_busy = 0, drop_count = 0, lane counter = 0, uses_left = 0.
- LFSR: Galois, right shift, taps 16'hB400. Steps exactly once per GEN cycle, otherwise holds.
- seed_load loads seed_val; seed_val = 0 loads SEED_DEFAULT instead.
- GEN cycle k (k = 0..LANES-1):
  - lane k is dropped iff lfsr_next[7:0] < thr_q, where lfsr_next is this cycle's stepped value and thr_q is drop_thresh latched at GEN entry;
  - mask bits build in a shadow register;
  - thr_q = 0 never drops.
- After lane LANES-1:
  - mask <= shadow;
  - drop_count <= popcount(~shadow);
  - uses_left <= max(reuse_cnt, 1);
  - state -> READY.
- States:
  - IDLE:
    - ena = 1 -> GEN.
    - ena = 0 -> stay in IDLE in bypass; mask forced to 8'hFF.
  - GEN:
    - LANES cycles, in_ready = 0.
    - ena falls -> abort to IDLE, mask = 8'hFF, shadow discarded.
  - READY:
    - Vectors accepted.
    - Each accept decrements uses_left; the accept that takes it to 0 -> GEN.
    - ena falls -> IDLE.
- seed_load:
  - In GEN: restart at lane 0 with the new seed.
  - In READY: the LFSR loads, the current mask stays valid for any handshake in the same cycle, next state is GEN.
  - In IDLE: loads only.
- Handshake:
  - Single output register, 1-cycle latency.
  - in_ready = (state == READY, or state == IDLE with ena = 0) && (!out_valid || out_ready).
  - Accept (in_valid && in_ready): out_data <= in_data & mask (bypass: in_data), out_valid <= 1.
  - Otherwise out_ready && out_valid clears out_valid.
  - out_data and out_valid hold while out_valid && !out_ready.
  - The mask used is the value before any update in the same cycle.
- Mask changes only at GEN exit, abort, or reset; never while a vector is in flight.
- A reset mid-GEN or mid-stream returns all reset values next cycle and drops any in-flight vector.

Test Plan:
- Reset: assert rst_n = 1 for 2 cycles with random inputs -> mask = FF, out_valid = 0, drop_count = 0, gen_busy = 0, in_ready = 0 on the first cycle after release if ena = 1.
- Bypass: ena = 0, in_data = 8'h5A with in_valid -> out_data = 5A one cycle later, no gen_busy.
- thr = 0, ena = 1: gen_busy high for exactly 8 cycles -> mask = FF, drop_count = 0, in_data = A5 -> out_data = A5.
- thr = 8'h80, seed = 16'h1234, reuse_cnt = 2: mask and drop_count match the golden LFSR model; 2 accepted vectors use the same mask, then gen_busy rises the cycle after the 2nd accept; the next mask matches the model's next 8 steps.
- Backpressure: out_ready = 0 for 5 cycles -> out_data stable, in_ready = 0, no vector lost or duplicated.
- seed_load at GEN lane 4 -> GEN restarts at lane 0 and the final mask equals the model from the new seed. ena drops mid-GEN -> IDLE with mask = FF. seed_val = 0 -> LFSR = ACE1.

Source files
------------

// File: rtl/dropout_mask_scheduler_if.sv
// Vector stream between producer, dropout scheduler and consumer.
// The master drives vectors in and takes them out; the slave is the scheduler.
interface dropout_mask_scheduler_if #(
  parameter int LANES = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/dropout_mask_scheduler.sv
// Builds a per-lane dropout mask from a Galois LFSR, one lane per cycle, and
// applies it to a stream of neuron vectors, reusing each mask for reuse_cnt vectors.
module dropout_mask_scheduler #(
  parameter int               LANES        = 8,
  parameter int               LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int               REUSE_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [7:0]          drop_thresh,
  input  logic [REUSE_W-1:0]  reuse_cnt,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed_val,
  dropout_mask_scheduler_if.slave bus,
  output logic [LANES-1:0]    mask,
  output logic                gen_busy,
  output logic [3:0]          drop_count
);

  localparam int                LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [LFSR_W-1:0]    lfsr;
  logic [LFSR_W-1:0]    lfsr_nxt;
  logic [LFSR_W-1:0]    seed_eff;
  logic [LANE_W-1:0]    lane;
  logic [REUSE_W-1:0]   uses_left;
  logic [7:0]           thr_q;
  logic [LANES-1:0]     shadow;
  logic [LANES-1:0]     shadow_fin;
  logic                 keep_bit;
  logic                 last_lane;
  logic                 accept;
  logic                 gen_enter;
  logic                 gen_step;
  logic                 gen_done;
  logic                 abort;
  logic                 out_valid_r;
  logic [LANES-1:0]     out_data_r;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [3:0] count_zeros(input logic [LANES-1:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      if (!m[i]) c = c + 4'd1;
    end
    return c;
  endfunction

  assign lfsr_nxt  = lfsr_step(lfsr);
  assign seed_eff  = (seed_val == '0) ? SEED_DEFAULT : seed_val;
  assign keep_bit  = !(lfsr_nxt[7:0] < thr_q);
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign gen_busy  = (state == GEN);

  assign bus.in_ready  = ((state == READY) || ((state == IDLE) && !ena)) &&
                         (!out_valid_r || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  always_comb begin
    shadow_fin       = shadow;
    shadow_fin[lane] = keep_bit;
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // A seed_load in GEN restarts the walk; a seed_load in READY forces a fresh mask.
  always_comb begin
    state_nxt = state;
    gen_enter = 1'b0;
    gen_step  = 1'b0;
    gen_done  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          state_nxt = GEN;
          gen_enter = 1'b1;
        end
      end
      GEN: begin
        if (!ena) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (!seed_load) begin
          gen_step = 1'b1;
          if (last_lane) begin
            state_nxt = READY;
            gen_done  = 1'b1;
          end
        end
      end
      READY: begin
        if (!ena) begin
          state_nxt = IDLE;
        end else if (seed_load || (accept && (uses_left == REUSE_W'(1)))) begin
          state_nxt = GEN;
          gen_enter = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control and output register stage ----
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lfsr        <= SEED_DEFAULT;
      mask        <= '1;
      drop_count  <= 4'd0;
      lane        <= '0;
      uses_left   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      if (seed_load)     lfsr <= seed_eff;
      else if (gen_step) lfsr <= lfsr_nxt;

      lane <= (gen_step && !last_lane) ? lane + LANE_W'(1) : '0;

      if (gen_done)
        mask <= shadow_fin;
      else if (abort || ((state == IDLE) && !ena))
        mask <= '1;

      if (gen_done) drop_count <= count_zeros(shadow_fin);

      if (gen_done)
        uses_left <= (reuse_cnt == '0) ? REUSE_W'(1) : reuse_cnt;
      else if ((state == READY) && accept && (uses_left != '0))
        uses_left <= uses_left - REUSE_W'(1);

      // Masking uses the mask held before any update in this same cycle.
      if (accept) begin
        out_valid_r <= 1'b1;
        out_data_r  <= (state == IDLE) ? bus.in_data : (bus.in_data & mask);
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // ---- mask build stage ----
  always_ff @(posedge clk) begin
    if (gen_enter) thr_q <= drop_thresh;
    if (gen_step)  shadow[lane] <= keep_bit;
  end

endmodule

// File: tb/tb_dropout_mask_scheduler.sv
// Directed bench for dropout_mask_scheduler: reset, bypass, mask generation,
// mask reuse, backpressure, seed reload mid-generation and abort.
module tb_dropout_mask_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  drop_thresh;
  logic [3:0]  reuse_cnt;
  logic        seed_load;
  logic [15:0] seed_val;
  logic [7:0]  mask;
  logic        gen_busy;
  logic [3:0]  drop_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] ml;
  logic [7:0]  m1, m2, m3, m4;
  int          n;

  dropout_mask_scheduler_if #(.LANES(8)) bus ();

  dropout_mask_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .drop_thresh(drop_thresh),
    .reuse_cnt  (reuse_cnt),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .bus        (bus),
    .mask       (mask),
    .gen_busy   (gen_busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gen(output int cnt);
    cnt = 0;
    while (gen_busy && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  // Golden Galois LFSR walk over 8 lanes against a threshold.
  task automatic model_gen(input logic [15:0] s_in, input logic [7:0] thr,
                           output logic [15:0] s_out, output logic [7:0] m);
    logic [15:0] s;
    s = s_in;
    m = 8'h00;
    for (int k = 0; k < 8; k++) begin
      s    = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
      m[k] = (s[7:0] < thr) ? 1'b0 : 1'b1;
    end
    s_out = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ena           = 1'($urandom);
      drop_thresh   = 8'($urandom);
      reuse_cnt     = 4'($urandom);
      seed_load     = 1'($urandom);
      seed_val      = 16'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom);
      tick();
    end

    // Release with ena high: still IDLE, so nothing is accepted yet.
    rst_n         = 1'b0;
    ena           = 1'b1;
    seed_load     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drop_thresh   = 8'h00;
    reuse_cnt     = 4'd1;
    #1;
    chk("rst_mask", 32'(mask), 32'hFF);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);
    chk("rst_gen_busy", 32'(gen_busy), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    ena = 1'b0;

    // Bypass
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    #1;
    chk("byp_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("byp_out_valid", 32'(bus.out_valid), 32'h1);
    chk("byp_out_data", 32'(bus.out_data), 32'h5A);
    chk("byp_gen_busy", 32'(gen_busy), 32'h0);
    tick();
    chk("byp_drain", 32'(bus.out_valid), 32'h0);

    // Zero threshold keeps every lane
    ena = 1'b1;
    tick();
    chk("thr0_in_ready", 32'(bus.in_ready), 32'h0);
    wait_gen(n);
    chk("thr0_gen_cycles", 32'(n), 32'd8);
    chk("thr0_mask", 32'(mask), 32'hFF);
    chk("thr0_drop_count", 32'(drop_count), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #1;
    chk("thr0_in_ready_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("thr0_out_data", 32'(bus.out_data), 32'hA5);
    chk("thr0_out_valid", 32'(bus.out_valid), 32'h1);
    ena = 1'b0;
    tick();
    chk("thr0_abort_busy", 32'(gen_busy), 32'h0);
    chk("thr0_abort_mask", 32'(mask), 32'hFF);

    // Seeded mask, reused for two vectors
    seed_load   = 1'b1;
    seed_val    = 16'h1234;
    drop_thresh = 8'h80;
    reuse_cnt   = 4'd2;
    tick();
    seed_load = 1'b0;
    ena       = 1'b1;
    tick();
    wait_gen(n);
    chk("m1_gen_cycles", 32'(n), 32'd8);
    model_gen(16'h1234, 8'h80, ml, m1);
    chk("m1_mask", 32'(mask), 32'(m1));
    chk("m1_drop_count", 32'(drop_count), 32'($countones(~m1)));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    tick();
    chk("m1_vec1", 32'(bus.out_data), 32'(8'hC3 & m1));
    chk("m1_busy_after1", 32'(gen_busy), 32'h0);
    bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    chk("m1_vec2", 32'(bus.out_data), 32'(8'h3C & m1));
    chk("m1_busy_after2", 32'(gen_busy), 32'h1);
    wait_gen(n);
    chk("m2_gen_cycles", 32'(n), 32'd8);
    model_gen(ml, 8'h80, ml, m2);
    chk("m2_mask", 32'(mask), 32'(m2));

    // Backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h96;
    #1;
    chk("bp_in_ready_first", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_data = 8'h69;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready_held", 32'(bus.in_ready), 32'h0);
      chk("bp_out_valid_held", 32'(bus.out_valid), 32'h1);
      chk("bp_out_data_held", 32'(bus.out_data), 32'(8'h96 & m2));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_vec", 32'(bus.out_data), 32'(8'h69 & m2));
    chk("bp_second_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_regen_busy", 32'(gen_busy), 32'h1);
    tick();
    chk("bp_no_duplicate", 32'(bus.out_valid), 32'h0);

    // Reseed at lane 4 of the running generation
    tick();
    tick();
    tick();
    seed_load = 1'b1;
    seed_val  = 16'hBEEF;
    tick();
    seed_load = 1'b0;
    chk("reseed_busy", 32'(gen_busy), 32'h1);
    wait_gen(n);
    chk("reseed_gen_cycles", 32'(n), 32'd8);
    model_gen(16'hBEEF, 8'h80, ml, m3);
    chk("reseed_mask", 32'(mask), 32'(m3));
    chk("reseed_drop_count", 32'(drop_count), 32'($countones(~m3)));

    // ena falls mid-generation
    seed_load = 1'b1;
    seed_val  = 16'h1111;
    tick();
    seed_load = 1'b0;
    chk("abort_busy_pre", 32'(gen_busy), 32'h1);
    tick();
    tick();
    ena = 1'b0;
    tick();
    chk("abort_busy", 32'(gen_busy), 32'h0);
    chk("abort_mask", 32'(mask), 32'hFF);
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);

    // Zero seed falls back to the default seed
    seed_load = 1'b1;
    seed_val  = 16'h0000;
    tick();
    seed_load   = 1'b0;
    ena         = 1'b1;
    drop_thresh = 8'hC0;
    tick();
    wait_gen(n);
    chk("zseed_gen_cycles", 32'(n), 32'd8);
    model_gen(16'hACE1, 8'hC0, ml, m4);
    chk("zseed_mask", 32'(mask), 32'(m4));
    chk("zseed_drop_count", 32'(drop_count), 32'($countones(~m4)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
